// File: rtl/led_channel_mux.sv
// ---------------------------------------------------------------------------
// LedChannelMux: N:1 channel selector driving a single LED.
//
// Two active-low push buttons (NEXT/PREV) are synchronised and debounced.
// They step a registered channel pointer that wraps at both ends. When
// auto-scan mode is selected, the pointer advances on a fixed period and the
// buttons are ignored. The LED shows the currently selected data input,
// registered.
//
// Parameters:
//   SEL_W           select width, CHANNELS = 2**SEL_W data inputs
//   DEBOUNCE_CYCLES consecutive stable synced cycles before a button is accepted
//   SCAN_PERIOD     clk cycles per auto-scan step
//
// Ports:
//   clk      system clock, everything on the rising edge
//   rst      synchronous reset, active-high
//   data     channel inputs, data[i] is channel i
//   btn_n    asynchronous active-low buttons, [0]=NEXT, [1]=PREV
//   mode     0 = manual (buttons), 1 = auto-scan
//   sel_out  current channel pointer (registered)
//   led      registered data[sel_out]
// ---------------------------------------------------------------------------
module led_channel_mux #(
  parameter int SEL_W           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_PERIOD     = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2**SEL_W-1:0] data,
  input  logic [1:0]          btn_n,
  input  logic                mode,
  output logic [SEL_W-1:0]    sel_out,
  output logic                led
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SCAN_W = $clog2(SCAN_PERIOD) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

  logic [1:0]        sync_a;
  logic [1:0]        sync_b;
  logic [1:0]        db;
  logic [1:0]        db_q;
  logic [DB_W-1:0]   db_cnt [2];
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        press;

  // Two-flop synchroniser. The raw buttons are asynchronous to clk, so
  // nothing else in the block may look at btn_n directly. Reset loads the
  // released level so that no press is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
    end
  end

  // Debouncer, one counter per button. The counter measures how long the
  // synced level has disagreed with the accepted level. A level is accepted
  // only after DEBOUNCE_CYCLES consecutive disagreeing samples. Any sample
  // that agrees again restarts the count, so a bounce never gets through.
  // db_q keeps last cycle's accepted level for the edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      db   <= 2'b11;
      db_q <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync_b[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A press is the 1->0 transition of the accepted level. This produces a
  // single pulse per press: holding the button does not repeat it, and
  // releasing the button produces no pulse.
  assign press = db_q & ~db;

  // Channel pointer and scan timer.
  // In auto mode the pointer steps once every SCAN_PERIOD cycles and button
  // pulses are dropped. In manual mode the timer is held at zero, so
  // re-entering auto mode always gives a full period before the first step.
  // NEXT and PREV pulses in the same cycle cancel each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_out  <= '0;
      scan_cnt <= '0;
    end else if (mode) begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        sel_out  <= sel_out + SEL_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end else begin
      scan_cnt <= '0;
      if (press == 2'b01) begin
        sel_out <= sel_out + SEL_W'(1);
      end else if (press == 2'b10) begin
        sel_out <= sel_out - SEL_W'(1);
      end
    end
  end

  // LED output register: the LED follows the selected channel one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= data[sel_out];
    end
  end

endmodule

// File: tb/tb_led_channel_mux.sv
// ---------------------------------------------------------------------------
// TbLedChannelMux: self-checking bench for led_channel_mux.
//
// Each applied cycle runs a behavioural model of the selector. The model
// describes the behaviour directly: a two-sample input delay, acceptance after
// N agreeing samples, a modulo pointer, and a scan step every P auto cycles.
// Its expected sel_out/led is pushed into a queue. A separate monitor pops one
// entry on every falling edge and compares it with the DUT. Directed scenarios
// also pin a few hand-derived values, and they are followed by a random phase.
// ---------------------------------------------------------------------------
module tb_led_channel_mux;

  localparam int SEL_W           = 2;
  localparam int CHANNELS        = 2**SEL_W;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int SCAN_PERIOD     = 8;

  logic                clk   = 1'b0;
  logic                rst   = 1'b1;
  logic [CHANNELS-1:0] data  = '0;
  logic [1:0]          btn_n = 2'b11;
  logic                mode  = 1'b0;
  logic [SEL_W-1:0]    sel_out;
  logic                led;

  led_channel_mux #(
    .SEL_W          (SEL_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SCAN_PERIOD    (SCAN_PERIOD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .btn_n  (btn_n),
    .mode   (mode),
    .sel_out(sel_out),
    .led    (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic             led;
  } expect_t;

  expect_t expectQ[$];

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state
  logic [1:0] rawDelay[$];
  bit         accepted[2];
  int         runLen[2];
  bit         fell[2];
  int         modelSel;
  int         autoEdges;

  // Shared comparison routine: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic modelReset();
    rawDelay  = {2'b11, 2'b11};
    accepted  = '{1'b1, 1'b1};
    runLen    = '{0, 0};
    fell      = '{1'b0, 1'b0};
    modelSel  = 0;
    autoEdges = 0;
  endtask

  // One rising edge of the behavioural model using the inputs currently driven.
  task automatic modelStep(output expect_t e);
    logic [1:0] synced;
    bit pressNext;
    bit pressPrev;
    if (rst) begin
      modelReset();
      e.sel = '0;
      e.led = 1'b0;
    end else begin
      pressNext = fell[0];
      pressPrev = fell[1];
      e.led = data[modelSel];
      if (mode) begin
        autoEdges++;
        if (autoEdges % SCAN_PERIOD == 0) modelSel = (modelSel + 1) % CHANNELS;
      end else begin
        autoEdges = 0;
        if (pressNext && !pressPrev)      modelSel = (modelSel + 1) % CHANNELS;
        else if (pressPrev && !pressNext) modelSel = (modelSel + CHANNELS - 1) % CHANNELS;
      end
      synced = rawDelay.pop_front();
      rawDelay.push_back(btn_n);
      for (int i = 0; i < 2; i++) begin
        fell[i] = 1'b0;
        if (synced[i] != accepted[i]) begin
          runLen[i]++;
          if (runLen[i] == DEBOUNCE_CYCLES) begin
            accepted[i] = synced[i];
            runLen[i]   = 0;
            fell[i]     = !accepted[i];
          end
        end else begin
          runLen[i] = 0;
        end
      end
      e.sel = SEL_W'(modelSel);
    end
  endtask

  // Drive inputs for n cycles; each cycle's expectation goes to the scoreboard.
  task automatic applyStimulus(input logic r, input logic [CHANNELS-1:0] d,
                               input logic [1:0] b, input logic m, input int n);
    expect_t e;
    rst   = r;
    data  = d;
    btn_n = b;
    mode  = m;
    for (int k = 0; k < n; k++) begin
      modelStep(e);
      expectQ.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the expectation for the edge just past and compares.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (expectQ.size() > 0) begin
        expect_t e;
        e = expectQ.pop_front();
        cyc++;
        checkOutput($sformatf("sb_sel@%0d", cyc), 32'(sel_out), 32'(e.sel));
        checkOutput($sformatf("sb_led@%0d", cyc), 32'(led), 32'(e.led));
      end
    end
  end

  // Stimulus
  initial begin
    int drain;
    modelReset();

    // Reset with all channels high; led must follow channel 0 once released
    applyStimulus(1'b1, 4'b1111, 2'b11, 1'b0, 3);
    checkOutput("reset_sel", 32'(sel_out), 32'd0);
    checkOutput("reset_led", 32'(led), 32'd0);
    applyStimulus(1'b0, 4'b1111, 2'b11, 1'b0, 1);
    checkOutput("post_reset_led", 32'(led), 32'd1);

    // NEXT held: sel moves at edge 7, led at edge 8, only one step
    applyStimulus(1'b0, 4'b0010, 2'b10, 1'b0, 6);
    checkOutput("next_before_edge7", 32'(sel_out), 32'd0);
    applyStimulus(1'b0, 4'b0010, 2'b10, 1'b0, 1);
    checkOutput("next_edge7_sel", 32'(sel_out), 32'd1);
    checkOutput("next_edge7_led", 32'(led), 32'd0);
    applyStimulus(1'b0, 4'b0010, 2'b10, 1'b0, 1);
    checkOutput("next_edge8_led", 32'(led), 32'd1);
    applyStimulus(1'b0, 4'b0010, 2'b10, 1'b0, 12);
    checkOutput("next_held_once", 32'(sel_out), 32'd1);
    applyStimulus(1'b0, 4'b0010, 2'b11, 1'b0, 10);
    checkOutput("release_no_step", 32'(sel_out), 32'd1);

    // Bounce must be rejected, a clean press accepted once
    applyStimulus(1'b0, 4'b0110, 2'b10, 1'b0, 3);
    applyStimulus(1'b0, 4'b0110, 2'b11, 1'b0, 1);
    applyStimulus(1'b0, 4'b0110, 2'b10, 1'b0, 3);
    applyStimulus(1'b0, 4'b0110, 2'b11, 1'b0, 10);
    checkOutput("bounce_rejected", 32'(sel_out), 32'd1);
    applyStimulus(1'b0, 4'b0110, 2'b10, 1'b0, 8);
    applyStimulus(1'b0, 4'b0110, 2'b11, 1'b0, 8);
    checkOutput("clean_press", 32'(sel_out), 32'd2);

    // Wrap in both directions, simultaneous presses cancel
    applyStimulus(1'b0, 4'b1001, 2'b10, 1'b0, 8);
    applyStimulus(1'b0, 4'b1001, 2'b11, 1'b0, 8);
    checkOutput("to_three", 32'(sel_out), 32'd3);
    applyStimulus(1'b0, 4'b1001, 2'b10, 1'b0, 8);
    applyStimulus(1'b0, 4'b1001, 2'b11, 1'b0, 8);
    checkOutput("wrap_next", 32'(sel_out), 32'd0);
    applyStimulus(1'b0, 4'b1001, 2'b01, 1'b0, 8);
    applyStimulus(1'b0, 4'b1001, 2'b11, 1'b0, 8);
    checkOutput("wrap_prev", 32'(sel_out), 32'd3);
    applyStimulus(1'b0, 4'b1001, 2'b00, 1'b0, 8);
    applyStimulus(1'b0, 4'b1001, 2'b11, 1'b0, 8);
    checkOutput("both_cancel", 32'(sel_out), 32'd3);
    applyStimulus(1'b0, 4'b1001, 2'b01, 1'b0, 8);
    applyStimulus(1'b0, 4'b1001, 2'b11, 1'b0, 8);
    checkOutput("prev_to_two", 32'(sel_out), 32'd2);

    // Auto-scan from 2: 3, 0, 1 at 8-cycle intervals
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b1, 7);
    checkOutput("scan_not_yet", 32'(sel_out), 32'd2);
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b1, 1);
    checkOutput("scan_step1", 32'(sel_out), 32'd3);
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b1, 8);
    checkOutput("scan_step2", 32'(sel_out), 32'd0);
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b1, 8);
    checkOutput("scan_step3", 32'(sel_out), 32'd1);
    // PREV pressed while scanning is ignored
    applyStimulus(1'b0, 4'b0101, 2'b01, 1'b1, 8);
    checkOutput("scan_prev_ignored", 32'(sel_out), 32'd2);
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b1, 8);
    checkOutput("scan_step5", 32'(sel_out), 32'd3);
    // Leave auto mid-period; re-entry restarts a full period
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b1, 3);
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b0, 2);
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b1, 7);
    checkOutput("reentry_not_yet", 32'(sel_out), 32'd3);
    applyStimulus(1'b0, 4'b0101, 2'b11, 1'b1, 1);
    checkOutput("reentry_step", 32'(sel_out), 32'd0);

    // Reset in the middle of debounce with the button held
    applyStimulus(1'b0, 4'b0011, 2'b11, 1'b0, 4);
    applyStimulus(1'b0, 4'b0011, 2'b10, 1'b0, 4);
    applyStimulus(1'b1, 4'b0011, 2'b10, 1'b0, 1);
    applyStimulus(1'b0, 4'b0011, 2'b10, 1'b0, 6);
    checkOutput("rst_mid_db_wait", 32'(sel_out), 32'd0);
    applyStimulus(1'b0, 4'b0011, 2'b10, 1'b0, 1);
    checkOutput("rst_mid_db_press", 32'(sel_out), 32'd1);
    applyStimulus(1'b0, 4'b0011, 2'b11, 1'b0, 8);

    // Randomised phase, checked by the scoreboard only
    for (int it = 0; it < 250; it++) begin
      logic       r;
      logic       m;
      logic [1:0] b;
      int         len;
      r   = ($urandom_range(0, 24) == 0);
      m   = ($urandom_range(0, 3) == 0);
      b   = 2'($urandom_range(0, 3));
      len = r ? 1 : int'($urandom_range(1, 12));
      applyStimulus(r, CHANNELS'($urandom), b, m, len);
    end

    // Let the monitor consume the last expectations, bounded
    drain = 0;
    while (expectQ.size() > 0 && drain < 5) begin
      @(negedge clk);
      #1;
      drain++;
    end
    checkOutput("scoreboard_drained", 32'(expectQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
